// File: rtl/gnn_result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gnn_result_collector                                          |
// | Function : Captures per-slot GNN results on their ready flags, buffers   |
// |            one result set, then streams it out in slot order with a      |
// |            valid/ready handshake and signed saturation to OW bits.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gnn_result_collector #(
    parameter int NODES   = 4,
    parameter int OUTS    = 2,
    parameter int DW      = 21,
    parameter int OW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NODES*OUTS*DW-1:0]        res_in,
    input  logic [NODES*OUTS-1:0]           res_rdy,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [OW-1:0]                   m_data,
    output logic [$clog2(NODES*OUTS)-1:0]   m_idx,
    output logic                            m_last,
    output logic                            m_sat,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int c_SLOTS = NODES * OUTS;
    localparam int c_IW    = $clog2(c_SLOTS);
    localparam int c_TW    = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN   = 2'd2;

    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_SLOTS - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    localparam logic [OW-1:0] c_POS_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] c_NEG_MIN = {1'b1, {(OW-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_SLOTS-1:0] r_cap_mask;
    logic [c_IW-1:0]    r_ptr;
    logic [c_TW-1:0]    r_tmo_cnt;
    logic               r_err;
    logic               r_done;
    logic [DW-1:0]      r_buf [c_SLOTS];

    logic [c_SLOTS-1:0] w_new;
    logic               w_full;
    logic               w_tmo;
    logic               w_drain;
    logic               w_fire;
    logic               w_last;
    logic [DW-1:0]      w_sel;
    logic [DW-OW:0]     w_hi;
    logic               w_clip;
    logic [OW-1:0]      w_sat_val;

    // Slots ready now but not yet latched; the frame is complete once every slot is held
    assign w_new   = res_rdy & ~r_cap_mask;
    assign w_full  = &(r_cap_mask | w_new);
    assign w_tmo   = (r_tmo_cnt == c_TMO_LAST);
    assign w_drain = (r_state == c_ST_DRAIN);
    assign w_last  = (r_ptr == c_LAST_IDX);
    assign w_fire  = w_drain & m_ready;

    // Clip when the bits above the output sign bit disagree with it
    assign w_sel     = r_buf[r_ptr];
    assign w_hi      = w_sel[DW-1:OW-1];
    assign w_clip    = !((&w_hi) || !(|w_hi));
    assign w_sat_val = w_clip ? (w_sel[DW-1] ? c_NEG_MIN : c_POS_MAX) : w_sel[OW-1:0];

    assign m_valid = w_drain;
    assign m_idx   = w_drain ? r_ptr : '0;
    assign m_data  = w_drain ? w_sat_val : '0;
    assign m_sat   = w_drain & w_clip;
    assign m_last  = w_drain & w_last;
    assign busy    = (r_state != c_ST_IDLE);
    assign done    = r_done;
    assign err     = r_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: capture ends on a full mask or on timeout, drain ends on the last accepted beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_CAPTURE;
                end
            end
            c_ST_CAPTURE: begin
                if (w_full || w_tmo) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_fire && w_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Datapath: frame setup on start, first-edge-wins slot capture, timeout, drain pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_mask <= '0;
            r_ptr      <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            for (int s = 0; s < c_SLOTS; s++) begin
                r_buf[s] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_cap_mask <= '0;
                        r_tmo_cnt  <= '0;
                        r_err      <= 1'b0;
                        r_ptr      <= '0;
                        // Slots that never arrive must stream zero, not a stale value
                        for (int s = 0; s < c_SLOTS; s++) begin
                            r_buf[s] <= '0;
                        end
                    end
                end
                c_ST_CAPTURE: begin
                    for (int s = 0; s < c_SLOTS; s++) begin
                        if (w_new[s]) begin
                            r_buf[s] <= res_in[s*DW +: DW];
                        end
                    end
                    r_cap_mask <= r_cap_mask | w_new;
                    if (!w_full) begin
                        if (w_tmo) begin
                            r_err <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_ptr  <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + c_IW'(1);
                        end
                    end
                end
                default: begin
                    r_ptr <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gnn_result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gnn_result_collector                                       |
// | Function : Randomized scoreboard bench for gnn_result_collector.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_gnn_result_collector;

    localparam int NODES   = 4;
    localparam int OUTS    = 2;
    localparam int DW      = 21;
    localparam int OW      = 16;
    localparam int TIMEOUT = 16;
    localparam int SLOTS   = NODES * OUTS;
    localparam int NJ      = 22;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [SLOTS*DW-1:0] res_in;
    logic [SLOTS-1:0]    res_rdy;
    logic                m_valid;
    logic                m_ready;
    logic [OW-1:0]       m_data;
    logic [2:0]          m_idx;
    logic                m_last;
    logic                m_sat;
    logic                busy;
    logic                done;
    logic                err;

    gnn_result_collector #(
        .NODES(NODES), .OUTS(OUTS), .DW(DW), .OW(OW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .res_in(res_in), .res_rdy(res_rdy),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
        .m_last(m_last), .m_sat(m_sat), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
        bit last;
        bit sat;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp      = 0;
    int    n_bad      = 0;
    int    done_cnt   = 0;
    int    ready_mode = 0;
    bit    rst_fired  = 0;
    int    rdy_at [SLOTS];
    int    vals   [NJ+1][SLOTS];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clip16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rand_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 65535)) - 32768;
            1:       return int'($urandom_range(0, 2097151)) - 1048576;
            2:       return 32766 + int'($urandom_range(0, 2));
            default: return -32769 + int'($urandom_range(0, 2));
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"},  m_data,  0);
        chk({tag, "_m_idx"},   m_idx,   0);
        chk({tag, "_m_last"},  m_last,  0);
        chk({tag, "_m_sat"},   m_sat,   0);
        chk({tag, "_busy"},    busy,    0);
        chk({tag, "_done"},    done,    0);
        chk({tag, "_err"},     err,     0);
    endtask

    // Asynchronous reset in the middle of a drain; pending beats are discarded
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        rst_fired = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk_zero("midrst_release");
    endtask

    // sched: 0 all at once, 1 staggered 7..0, 2 random, 3 slots 6/7 never, 4 random with misses
    // vkind: 0 value 100*s, 1 random every cycle, 2 saturation corner values
    task automatic run_frame(input int sched, input int vkind, input int mode, input bit abort);
        int    d;
        int    maxr;
        bit    all_in;
        bit    exp_err;
        int    dc0;
        int    guard;
        int    v;
        beat_t b;
        ready_mode = mode;
        for (int s = 0; s < SLOTS; s++) begin
            case (sched)
                0:       rdy_at[s] = 1;
                1:       rdy_at[s] = 1 + ((SLOTS - 1 - s) * 10) / (SLOTS - 1);
                2:       rdy_at[s] = int'($urandom_range(1, 14));
                3:       rdy_at[s] = (s < 6) ? int'($urandom_range(1, 10)) : 0;
                default: rdy_at[s] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
            endcase
        end
        for (int j = 0; j <= NJ; j++) begin
            for (int s = 0; s < SLOTS; s++) begin
                case (vkind)
                    0:       vals[j][s] = 100 * s;
                    2:       vals[j][s] = (s == 0) ? 40000 : (s == 1) ? -40000 :
                                          (s == 2) ? -32768 : 1000 * s;
                    default: vals[j][s] = rand_val();
                endcase
            end
        end
        // Reference: capture completes at the latest ready edge, or is cut off at TIMEOUT
        all_in = 1'b1;
        maxr   = 0;
        for (int s = 0; s < SLOTS; s++) begin
            if (rdy_at[s] < 1 || rdy_at[s] > TIMEOUT) all_in = 1'b0;
            else if (rdy_at[s] > maxr) maxr = rdy_at[s];
        end
        d       = all_in ? maxr : TIMEOUT;
        exp_err = !all_in;
        for (int s = 0; s < SLOTS; s++) begin
            v      = (rdy_at[s] >= 1 && rdy_at[s] <= d) ? vals[rdy_at[s]][s] : 0;
            b.idx  = s;
            b.data = clip16(v);
            b.last = (s == SLOTS - 1);
            b.sat  = (clip16(v) != v);
            exp_q.push_back(b);
        end
        dc0       = done_cnt;
        rst_fired = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_err_clear", err, 0);
        for (int j = 1; j <= NJ; j++) begin
            for (int s = 0; s < SLOTS; s++) begin
                res_rdy[s]          = (rdy_at[s] >= 1 && j >= rdy_at[s]);
                res_in[s*DW +: DW]  = DW'(vals[j][s]);
            end
            start = busy && ($urandom_range(0, 3) == 0);
            tick();
            start = 1'b0;
            if (abort && !rst_fired && m_valid && m_idx == 3'd4) do_reset();
            if (!rst_fired) begin
                if (j == d) chk("first_beat_latency", m_valid, 1);
                if (j < d)  chk("capture_no_valid", m_valid, 0);
            end
        end
        guard = 0;
        while (done_cnt == dc0 && !rst_fired && guard < 300) begin
            start = busy && m_valid && ($urandom_range(0, 3) == 0);
            tick();
            start = 1'b0;
            if (abort && !rst_fired && m_valid && m_idx == 3'd4) do_reset();
            guard++;
        end
        if (!rst_fired) begin
            chk("frame_done_in_budget", (guard < 300), 1);
            chk("err_flag", err, exp_err);
        end
    endtask

    // Downstream ready: 0 always accept, 1 random, 2 stall idx 2 for three cycles
    initial begin
        int hold;
        hold    = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (m_valid && m_idx == 3'd2) begin
                        if (hold < 3) begin
                            m_ready = 1'b0;
                            hold++;
                        end else begin
                            m_ready = 1'b1;
                        end
                    end else begin
                        hold    = 0;
                        m_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each accepted beat, checks hold stability and done
    initial begin
        bit    prev_hold;
        bit    prev_go;
        bit    exp_done;
        beat_t pv;
        beat_t e;
        prev_hold = 1'b0;
        prev_go   = 1'b0;
        exp_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                prev_go   = 1'b0;
                exp_done  = 1'b0;
                continue;
            end
            chk("done_pulse", done, exp_done);
            if (done) done_cnt++;
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_idx",   m_idx,   pv.idx);
                chk("hold_data",  $signed(m_data), pv.data);
                chk("hold_last",  m_last,  pv.last);
                chk("hold_sat",   m_sat,   pv.sat);
            end
            if (prev_go) chk("no_bubble", m_valid, 1);
            exp_done  = 1'b0;
            prev_hold = 1'b0;
            prev_go   = 1'b0;
            if (m_valid && m_ready) begin
                chk("beat_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat_idx",  m_idx,  e.idx);
                    chk("beat_data", $signed(m_data), e.data);
                    chk("beat_last", m_last, e.last);
                    chk("beat_sat",  m_sat,  e.sat);
                end
                exp_done = m_last;
                prev_go  = !m_last;
            end else if (m_valid) begin
                prev_hold = 1'b1;
                pv.idx    = int'(m_idx);
                pv.data   = int'($signed(m_data));
                pv.last   = m_last;
                pv.sat    = m_sat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        res_in  = '0;
        res_rdy = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("in_reset");
        rst = 1'b0;
        tick();
        chk_zero("after_release");

        run_frame(0, 0, 0, 1'b0);   // all slots at once, 100*s
        run_frame(1, 1, 1, 1'b0);   // staggered readiness, changing data
        run_frame(0, 1, 2, 1'b0);   // stall on idx 2
        run_frame(0, 2, 0, 1'b0);   // saturation corners
        run_frame(3, 1, 1, 1'b0);   // timeout, slots 6/7 stream 0
        run_frame(0, 1, 1, 1'b0);   // next start clears err
        run_frame(0, 1, 1, 1'b1);   // reset during drain at idx 4
        run_frame(0, 0, 0, 1'b0);   // clean frame after reset
        for (int k = 0; k < 14; k++) begin
            run_frame(2 + 2 * int'($urandom_range(0, 1)), 1, int'($urandom_range(0, 1)), 1'b0);
        end

        repeat (10) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
